// File: rtl/seg7_seq_pkg.sv
// Shared types and tables for the sequenced 7-segment counter.
// SEQ maps a digit position to the hex value shown on that digit.
// SEG7_LUT maps a hex value to its segment pattern, bit6=a ... bit0=g.
package seg7_seq_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] seq_idx_t;

  localparam logic [3:0] SEQ [16] = '{
    4'h2, 4'h5, 4'h7, 4'h3, 4'hA, 4'hE, 4'h8, 4'h0,
    4'hB, 4'h4, 4'h6, 4'hD, 4'hF, 4'h1, 4'hC, 4'h9
  };

  localparam seg7_t SEG7_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Segment pattern for a hex value; common-anode displays want it inverted.
  function automatic seg7_t seg7_encode(input logic [3:0] hex, input logic active_low);
    seg7_t code;
    code = SEG7_LUT[hex];
    return active_low ? ~code : code;
  endfunction

endpackage

// File: rtl/seg7_seq_digit.sv
// One digit of the cascaded sequence counter: position register, load clamp,
// step up/down with rollover, and terminal/carry detection.
// Optional feature macro SEG7_SEQ_SAT_EN adds the lim_next output, which
// reports whether the next position sits at the limit of the current direction.
module seg7_seq_digit
  import seg7_seq_pkg::*;
#(
  parameter int SEQ_LEN = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  seq_idx_t load_val,
  input  logic     up,
  input  logic     carry_in,
  input  logic     hold,
  output seq_idx_t idx,
  output logic     carry_out
`ifdef SEG7_SEQ_SAT_EN
  ,
  output logic     lim_next
`endif
);

  localparam seq_idx_t LAST = seq_idx_t'(SEQ_LEN - 1);

  seq_idx_t idx_d, idx_q;
  seq_idx_t load_clamped;
  logic     terminal;
  logic     step;

  // Out-of-range load positions fall back to position 0.
  assign load_clamped = ({1'b0, load_val} >= 5'(SEQ_LEN)) ? '0 : load_val;
  // Terminal position depends on direction: last entry going up, first going down.
  assign terminal     = up ? (idx_q == LAST) : (idx_q == '0);
  assign carry_out    = carry_in & terminal;
  assign step         = carry_in & ~hold;

  // Next position: load wins, otherwise step with rollover when carried into.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = load_clamped;
    end else if (step) begin
      if (up) idx_d = terminal ? '0 : idx_q + 4'd1;
      else    idx_d = terminal ? LAST : idx_q - 4'd1;
    end
  end

  // Position register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign idx = idx_q;

`ifdef SEG7_SEQ_SAT_EN
  assign lim_next = up ? (idx_d == LAST) : (idx_d == '0);
`endif

endmodule

// File: rtl/seg7_seq_counter.sv
// Multi-digit up/down counter whose digits walk a fixed display sequence and
// drive 7-segment patterns. Digits cascade through a combinational carry
// ripple; all digits update on the same edge.
// Optional feature macro SEG7_SEQ_SAT_EN: saturate at the direction limit and
// turn wrap into a level "saturated" flag instead of a rollover pulse.
module seg7_seq_counter
  import seg7_seq_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int SEQ_LEN        = 16,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_idx,
  output logic [4*NUM_DIGITS-1:0] idx,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    wrap
);

  // carry[k] is high when digit k is allowed to step this edge.
  logic [NUM_DIGITS:0] carry;
  logic                all_roll;
  logic                hold;
  logic                wrap_d, wrap_q;

  assign carry[0] = en;
  // Every digit is terminal while enabled: a full-counter rollover (or a
  // blocked step when saturating).
  assign all_roll = carry[NUM_DIGITS];

`ifdef SEG7_SEQ_SAT_EN
  logic [NUM_DIGITS-1:0] lim_next;
  assign hold = all_roll;
`else
  assign hold = 1'b0;
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seq_idx_t dig_idx;

    seg7_seq_digit #(
      .SEQ_LEN (SEQ_LEN)
    ) u_digit (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_val  (load_idx[4*k +: 4]),
      .up        (up),
      .carry_in  (carry[k]),
      .hold      (hold),
      .idx       (dig_idx),
      .carry_out (carry[k+1])
`ifdef SEG7_SEQ_SAT_EN
      ,
      .lim_next  (lim_next[k])
`endif
    );

    assign idx[4*k +: 4]       = dig_idx;
    assign digit_val[4*k +: 4] = SEQ[dig_idx];
    assign seg[7*k +: 7]       = seg7_encode(SEQ[dig_idx], SEG_ACTIVE_LOW != 0);
  end

  // Wrap flag: rollover pulse, or level "at limit" flag when saturating.
  always_comb begin
    wrap_d = 1'b0;
    if (!load) begin
`ifdef SEG7_SEQ_SAT_EN
      wrap_d = &lim_next;
`else
      wrap_d = all_roll;
`endif
    end
  end

  // Wrap register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule
